// File: rtl/cache_bus_responder.sv
// cache_bus_responder
// Memory-side slave for the simplified AXI-style cache bus. Accepts one
// address request at a time, then either streams a read burst out of the
// internal word RAM or absorbs a write burst with per-byte enables.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   AXI_addr/_valid/_we      request byte address, request present, write flag
//   AXI_size                 beat size (unused: bus is always word-wide)
//   AXI_lens                 burst length in beats minus one
//   AXI_rd_rready            master accepts the current read beat
//   AXI_wr_data/_dready      write beat data and its valid strobe
//   AXI_byte_enable          per-byte write strobe, bit i covers data[8i+7:8i]
//   AXI_wr_last              master's end-of-burst marker (checked, not obeyed)
//   AXI_response_rready      master ready for the write response
//   AXI_rd/wr_addr_clear     one-cycle request-accepted pulses
//   AXI_rd_dready/_data/_last  read beat valid, data (0 when idle), final beat
//   AXI_wr_next              responder takes a write beat this cycle
//   AXI_wr_ok                write response, gated by AXI_response_rready
//   protocol_err             sticky: AXI_wr_last disagreed with the lens count
module cache_bus_responder #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int READ_LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] AXI_addr,
  input  logic        AXI_addr_valid,
  input  logic        AXI_we,
  input  logic [2:0]  AXI_size,
  input  logic [7:0]  AXI_lens,
  input  logic        AXI_rd_rready,
  input  logic [31:0] AXI_wr_data,
  input  logic        AXI_wr_dready,
  input  logic [3:0]  AXI_byte_enable,
  input  logic        AXI_wr_last,
  input  logic        AXI_response_rready,
  output logic        AXI_rd_addr_clear,
  output logic        AXI_wr_addr_clear,
  output logic        AXI_rd_dready,
  output logic [31:0] AXI_rd_data,
  output logic        AXI_rd_last,
  output logic        AXI_wr_next,
  output logic        AXI_wr_ok,
  output logic        protocol_err
);

  localparam int DEPTH = 2 ** MEM_ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE, R_ACK, R_WAIT, R_DATA, W_ACK, W_DATA, W_RESP
  } state_t;

  state_t                    state, state_nx;
  logic [MEM_ADDR_WIDTH-1:0] ptr;
  logic [7:0]                lens;
  logic [7:0]                beat;
  logic [3:0]                lat_cnt;
  logic [31:0]               mem [DEPTH];

  logic final_beat;
  logic wr_xfer;
  logic unused_bits;

  assign final_beat = (beat == lens);
  assign wr_xfer    = (state == W_DATA) && AXI_wr_dready;

  // Address bits outside the word index and the beat size carry no meaning here.
  assign unused_bits = ^{AXI_size, AXI_addr[31:MEM_ADDR_WIDTH+2], AXI_addr[1:0]};

  // NOTE: next state is assigned a default before the case so no path leaves
  // it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (AXI_addr_valid) state_nx = AXI_we ? W_ACK : R_ACK;
      R_ACK:   state_nx = R_WAIT;
      R_WAIT:  if (lat_cnt == 4'd0) state_nx = R_DATA;
      R_DATA:  if (AXI_rd_rready && final_beat) state_nx = IDLE;
      W_ACK:   state_nx = W_DATA;
      W_DATA:  if (AXI_wr_dready && final_beat) state_nx = W_RESP;
      W_RESP:  if (AXI_response_rready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: all state registers use non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= '0;
      lens         <= '0;
      beat         <= '0;
      lat_cnt      <= '0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (AXI_addr_valid) begin
            ptr  <= AXI_addr[MEM_ADDR_WIDTH+1:2];
            lens <= AXI_lens;
            beat <= '0;
          end
        end
        // The wait state runs counter values READ_LATENCY-1 down to 0, so it
        // lasts exactly READ_LATENCY cycles.
        R_ACK:  lat_cnt <= 4'(READ_LATENCY - 1);
        R_WAIT: lat_cnt <= lat_cnt - 1'b1;
        R_DATA: begin
          if (AXI_rd_rready) begin
            ptr  <= ptr + 1'b1;
            beat <= beat + 1'b1;
          end
        end
        W_DATA: begin
          if (AXI_wr_dready) begin
            ptr  <= ptr + 1'b1;
            beat <= beat + 1'b1;
            // lens alone ends the burst; a disagreeing wr_last is only flagged.
            if (AXI_wr_last != final_beat) protocol_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the RAM is deliberately left out of reset: contents survive a reset
  // and the array can map onto plain memory cells.
  always_ff @(posedge clk) begin
    if (wr_xfer) begin
      for (int i = 0; i < 4; i++) begin
        if (AXI_byte_enable[i]) mem[ptr][8*i +: 8] <= AXI_wr_data[8*i +: 8];
      end
    end
  end

  assign AXI_rd_addr_clear = (state == R_ACK);
  assign AXI_wr_addr_clear = (state == W_ACK);
  assign AXI_rd_dready     = (state == R_DATA);
  assign AXI_rd_data       = (state == R_DATA) ? mem[ptr] : 32'd0;
  assign AXI_rd_last       = (state == R_DATA) && final_beat;
  assign AXI_wr_next       = (state == W_DATA);
  assign AXI_wr_ok         = (state == W_RESP) && AXI_response_rready;

endmodule

// File: tb/tb_cache_bus_responder.sv
// Self-checking bench for cache_bus_responder. A transaction-level model
// (word array plus sticky error flag) predicts, cycle by cycle, what every
// output must show; a single negedge process compares against it. Literal
// checks pin the model to hand-computed values.
module tb_cache_bus_responder;

  localparam int MAW   = 4;
  localparam int RL    = 2;
  localparam int DEPTH = 1 << MAW;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] AXI_addr;
  logic        AXI_addr_valid;
  logic        AXI_we;
  logic [2:0]  AXI_size;
  logic [7:0]  AXI_lens;
  logic        AXI_rd_rready;
  logic [31:0] AXI_wr_data;
  logic        AXI_wr_dready;
  logic [3:0]  AXI_byte_enable;
  logic        AXI_wr_last;
  logic        AXI_response_rready;
  logic        AXI_rd_addr_clear;
  logic        AXI_wr_addr_clear;
  logic        AXI_rd_dready;
  logic [31:0] AXI_rd_data;
  logic        AXI_rd_last;
  logic        AXI_wr_next;
  logic        AXI_wr_ok;
  logic        protocol_err;

  cache_bus_responder #(.MEM_ADDR_WIDTH(MAW), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst),
    .AXI_addr(AXI_addr), .AXI_addr_valid(AXI_addr_valid), .AXI_we(AXI_we),
    .AXI_size(AXI_size), .AXI_lens(AXI_lens), .AXI_rd_rready(AXI_rd_rready),
    .AXI_wr_data(AXI_wr_data), .AXI_wr_dready(AXI_wr_dready),
    .AXI_byte_enable(AXI_byte_enable), .AXI_wr_last(AXI_wr_last),
    .AXI_response_rready(AXI_response_rready),
    .AXI_rd_addr_clear(AXI_rd_addr_clear), .AXI_wr_addr_clear(AXI_wr_addr_clear),
    .AXI_rd_dready(AXI_rd_dready), .AXI_rd_data(AXI_rd_data),
    .AXI_rd_last(AXI_rd_last), .AXI_wr_next(AXI_wr_next),
    .AXI_wr_ok(AXI_wr_ok), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rclr;
    logic        wclr;
    logic        rdv;
    logic [31:0] rdata;
    logic        rlast;
    logic        wnext;
    logic        wok;
    logic        err;
  } obs_t;

  obs_t        act_o;
  obs_t        exp_o;
  logic        chk_en;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model_mem [DEPTH];
  logic        model_err;
  logic [31:0] rd_got [$];

  assign act_o = {AXI_rd_addr_clear, AXI_wr_addr_clear, AXI_rd_dready, AXI_rd_data,
                  AXI_rd_last, AXI_wr_next, AXI_wr_ok, protocol_err};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
  endtask

  // Per-cycle comparison of every output against the model's prediction.
  always @(negedge clk) begin
    if (chk_en) check("cycle_outputs", 64'(act_o), 64'(exp_o));
  end

  function automatic obs_t mk_idle();
    obs_t o;
    o     = '0;
    o.err = model_err;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  // Write burst: beat b carries base+b; wr_last is raised on beat last_at.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] lens,
                          input logic [31:0] base, input logic [3:0] be,
                          input int last_at, input bit gaps, input int resp_delay);
    int ptr = word_of(addr);
    int b   = 0;
    int cyc = 0;
    bit dr;
    bit flag;
    AXI_addr = addr; AXI_we = 1'b1; AXI_lens = lens; AXI_addr_valid = 1'b1;
    exp_o = mk_idle();
    step();
    AXI_addr_valid = 1'b0;
    exp_o.wclr = 1'b1;
    step();
    exp_o.wclr  = 1'b0;
    exp_o.wnext = 1'b1;
    while (b <= int'(lens)) begin
      dr = gaps ? ((cyc % 3) != 2) : 1'b1;
      AXI_wr_dready   = dr;
      AXI_wr_data     = base + 32'(b);
      AXI_byte_enable = be;
      AXI_wr_last     = (b == last_at);
      flag = 1'b0;
      if (dr) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) model_mem[ptr][8*i +: 8] = AXI_wr_data[8*i +: 8];
        flag = ((b == last_at) != (b == int'(lens)));
      end
      step();
      if (dr) begin
        b++;
        ptr = (ptr + 1) % DEPTH;
      end
      if (flag) model_err = 1'b1;
      exp_o.err = model_err;
      cyc++;
    end
    AXI_wr_dready = 1'b0; AXI_wr_last = 1'b0;
    exp_o = mk_idle();
    repeat (resp_delay) step();
    AXI_response_rready = 1'b1;
    exp_o.wok = 1'b1;
    step();
    AXI_response_rready = 1'b0;
    exp_o = mk_idle();
  endtask

  // Read burst; toggle holds rd_rready low on every other data cycle starting
  // low; abort_beat >= 0 pulls reset in the cycle that beat is presented.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] lens,
                         input bit toggle, input int abort_beat);
    int ptr = word_of(addr);
    int b   = 0;
    int cyc = 0;
    bit rr;
    rd_got.delete();
    AXI_addr = addr; AXI_we = 1'b0; AXI_lens = lens; AXI_addr_valid = 1'b1;
    exp_o = mk_idle();
    step();
    AXI_addr_valid = 1'b0;
    exp_o.rclr = 1'b1;
    step();
    exp_o.rclr = 1'b0;
    repeat (RL) step();
    while (b <= int'(lens)) begin
      rr = toggle ? ((cyc % 2) == 1) : 1'b1;
      AXI_rd_rready = rr;
      exp_o.rdv   = 1'b1;
      exp_o.rdata = model_mem[ptr];
      exp_o.rlast = (b == int'(lens));
      if (b == abort_beat) begin
        @(negedge clk);
        #2;
        chk_en = 1'b0;
        rst    = 1'b0;
        #1;
        check("async_reset_outputs", 64'(act_o), 64'd0);
        model_err = 1'b0;
        @(posedge clk);
        #1;
        check("reset_held_outputs", 64'(act_o), 64'd0);
        rst = 1'b1;
        AXI_rd_rready = 1'b0;
        exp_o  = mk_idle();
        chk_en = 1'b1;
        return;
      end
      @(negedge clk);
      if (rr) rd_got.push_back(AXI_rd_data);
      step();
      if (rr) begin
        b++;
        ptr = (ptr + 1) % DEPTH;
      end
      cyc++;
    end
    AXI_rd_rready = 1'b0;
    exp_o = mk_idle();
  endtask

  initial begin
    rst = 1'b0; chk_en = 1'b0; model_err = 1'b0;
    AXI_addr = '0; AXI_addr_valid = 1'b0; AXI_we = 1'b0; AXI_size = 3'b010;
    AXI_lens = '0; AXI_rd_rready = 1'b0; AXI_wr_data = '0; AXI_wr_dready = 1'b0;
    AXI_byte_enable = '0; AXI_wr_last = 1'b0; AXI_response_rready = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    exp_o = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'(act_o), 64'd0);
    rst = 1'b1;
    exp_o = mk_idle();
    chk_en = 1'b1;
    step();

    // Single write then read.
    do_write(32'h40, 8'd0, 32'hDEADBEEF, 4'hF, 0, 1'b0, 0);
    do_read(32'h40, 8'd0, 1'b0, -1);
    check("t1_beats", 64'(rd_got.size()), 64'd1);
    check("t1_data", 64'(rd_got[0]), 64'h0000_0000_DEAD_BEEF);

    // Byte merge.
    do_write(32'h14, 8'd0, 32'h11223344, 4'hF, 0, 1'b0, 1);
    do_write(32'h14, 8'd0, 32'hAABBCCDD, 4'b0101, 0, 1'b0, 0);
    check("t2_model_merge", 64'(model_mem[5]), 64'h0000_0000_11BB_33DD);
    do_read(32'h14, 8'd0, 1'b0, -1);
    check("t2_data", 64'(rd_got[0]), 64'h0000_0000_11BB_33DD);

    // 16-beat burst, write gaps, read backpressure.
    do_write(32'h100, 8'd15, 32'd0, 4'hF, 15, 1'b1, 2);
    do_read(32'h100, 8'd15, 1'b1, -1);
    check("t3_beats", 64'(rd_got.size()), 64'd16);
    for (int i = 0; i < 16; i++) check("t3_data", 64'(rd_got[i]), 64'(i));

    // Wrap-around: words 14, 15, 0, 1.
    do_write(32'h38, 8'd3, 32'hCAFE0000, 4'hF, 3, 1'b0, 0);
    check("t4_model_w15", 64'(model_mem[15]), 64'h0000_0000_CAFE_0001);
    check("t4_model_w0", 64'(model_mem[0]), 64'h0000_0000_CAFE_0002);
    check("t4_model_w1", 64'(model_mem[1]), 64'h0000_0000_CAFE_0003);
    do_read(32'h38, 8'd3, 1'b0, -1);
    check("t4_data0", 64'(rd_got[0]), 64'h0000_0000_CAFE_0000);
    check("t4_data3", 64'(rd_got[3]), 64'h0000_0000_CAFE_0003);

    // Early wr_last: burst still four beats, error sticky.
    do_write(32'h20, 8'd3, 32'h55550000, 4'hF, 1, 1'b0, 0);
    check("t5_err_set", 64'(protocol_err), 64'd1);
    do_read(32'h20, 8'd3, 1'b0, -1);
    check("t5_last_beat", 64'(rd_got[3]), 64'h0000_0000_5555_0003);
    check("t5_err_sticky", 64'(protocol_err), 64'd1);

    // Reset during beat 2 of an 8-beat read, then RAM must be intact.
    do_read(32'h0, 8'd7, 1'b0, 2);
    check("t6_err_cleared", 64'(protocol_err), 64'd0);
    do_read(32'h38, 8'd0, 1'b0, -1);
    check("t6_ram_intact", 64'(rd_got[0]), 64'h0000_0000_CAFE_0000);
    // High and low address bits are ignored: this lands on word 0.
    do_read(32'hFFFF_FFC3, 8'd0, 1'b0, -1);
    check("t6_addr_mask", 64'(rd_got[0]), 64'h0000_0000_CAFE_0002);

    repeat (3) step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_bus_responder.md
# cache_bus_responder

Memory-side responder for the simplified AXI-style request bus driven by the data cache, uncache and instruction cache masters. It accepts one address request at a time and returns read bursts or absorbs write bursts with per-byte enables. Backing storage is an internal word-addressed RAM. It serves as the slave end for block-level cache benches and as the on-chip scratch memory behind the bus arbiter.

## Interface
Parameters:
- MEM_ADDR_WIDTH, 10: word-index width; RAM depth is 2**MEM_ADDR_WIDTH words.
- READ_LATENCY, 2: cycles from end of read accept to first beat; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- AXI_addr  in  32  request byte address; word index = AXI_addr[MEM_ADDR_WIDTH+1:2].
- AXI_addr_valid  in  1  request present; the master holds it with addr/we/lens until the clear pulse.
- AXI_we  in  1  1 = write burst, 0 = read burst.
- AXI_size  in  3  beat size; ignored; bus is word-wide.
- AXI_lens  in  8  beats minus one.
- AXI_rd_rready  in  1  master accepts a read beat.
- AXI_wr_data  in  32  write beat data.
- AXI_wr_dready  in  1  write beat valid.
- AXI_byte_enable  in  4  per-byte write strobe; bit i covers data[8i+7:8i].
- AXI_wr_last  in  1  master marks its final write beat.
- AXI_response_rready  in  1  master is ready for the write response.
- AXI_rd_addr_clear  out  1  one-cycle pulse; read request accepted.
- AXI_wr_addr_clear  out  1  one-cycle pulse; write request accepted.
- AXI_rd_dready  out  1  read beat valid.
- AXI_rd_data  out  32  read beat data; 0 when AXI_rd_dready=0.
- AXI_rd_last  out  1  final read beat.
- AXI_wr_next  out  1  responder accepts a write beat this cycle.
- AXI_wr_ok  out  1  write response.
- protocol_err  out  1  sticky; AXI_wr_last disagreed with the lens beat count.

## Operation
States are IDLE, R_ACK, R_WAIT, R_DATA, W_ACK, W_DATA and W_RESP.
- IDLE: on an edge with AXI_addr_valid=1, latch the word pointer (ptr), lens and we, and clear the beat counter.
  - Next state is W_ACK if we=1, otherwise R_ACK.
  - AXI_addr_valid is sampled only in IDLE.
- R_ACK: AXI_rd_addr_clear=1 for this cycle. Load the latency counter with READ_LATENCY-1, then go to R_WAIT.
- R_WAIT: decrement the counter each cycle. Go to R_DATA on the edge where the counter is 0.
- R_DATA:
  - Outputs: AXI_rd_dready=1, AXI_rd_data=mem[ptr], AXI_rd_last=(beat==lens).
  - A beat transfers on an edge with AXI_rd_rready=1; ptr and beat then increment.
  - After the transfer where rd_last=1, return to IDLE.
- W_ACK: AXI_wr_addr_clear=1 for this cycle, then go to W_DATA.
- W_DATA:
  - AXI_wr_next=1 throughout the state.
  - A beat transfers on an edge with AXI_wr_dready=1. Each byte lane i with byte_enable[i]=1 is written to mem[ptr]; other lanes keep their old value. ptr and beat then increment.
  - The beat where beat==lens is the final beat; it moves to W_RESP. AXI_wr_last does not end the burst; lens alone decides.
  - protocol_err sets if wr_last=1 on a non-final beat, or wr_last=0 on the final beat.
- W_RESP: AXI_wr_ok = AXI_response_rready, combinationally. On an edge with response_rready=1, return to IDLE.
- ptr increments by one word per beat and wraps modulo RAM depth. Address bits above the word index and bits [1:0] are ignored.
- beat is an 8-bit counter; lens=255 gives 256 beats.
- Reset, at any time including mid-burst:
  - Returns the block to IDLE; all outputs and protocol_err go to 0.
  - A partially written burst keeps the beats already written.
  - RAM contents are not reset.

## Timing
- Request accept: AXI_addr_valid is sampled at edge N. The clear pulse is high in cycle N+1 only.
- Read latency: the first AXI_rd_dready rises in cycle N+2+READ_LATENCY. With READ_LATENCY=1 that is cycle N+3.
- Back-to-back beats: with AXI_rd_rready held high, a read burst of lens+1 beats occupies lens+1 consecutive cycles.
- Write beats: AXI_wr_next is high from cycle N+2. With AXI_wr_dready held high, one beat is written per cycle.
- Write response: AXI_wr_ok is possible no earlier than the cycle after the final write beat.
- The earliest next request is sampled on the edge that leaves R_DATA or W_RESP plus one, i.e. from IDLE. A request held high across a return to IDLE is accepted again.
- Every output is a function of registered state only, except AXI_wr_ok, which is also gated by AXI_response_rready.

## Test plan
- Single write then read: write addr 0x40, lens 0, data 0xDEADBEEF, be 4'hF. Then read 0x40 lens 0 → rd_data 0xDEADBEEF, rd_last=1, clear pulses exactly one cycle each, wr_ok after one beat.
- Byte merge: write 0x11223344 to word 5, then write 0xAABBCCDD with be 4'b0101 → read returns 0x11BB33DD.
- Burst with backpressure: write 16 beats (lens 15) at 0x100 with data = index. Read back while toggling rd_rready every other cycle → 16 beats in order, rd_last only on beat 15, data held stable while rd_rready=0.
- Wrap-around: MEM_ADDR_WIDTH=4, write lens 3 at word 14 → words 14, 15, 0, 1 are written, read back identical.
- Protocol error: write lens 3 with wr_last on beat 1 → 4 beats still absorbed, protocol_err=1 and stays set until reset.
- Reset mid-read: assert rst low in R_DATA beat 2 of 8 → all outputs 0 asynchronously. After release a fresh lens 0 read is accepted normally and RAM is intact.
